// File: rtl/knock_lock_pkg.sv
// Shared types, default timing constants and width helper for the knock lock controller.
package knock_lock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    CHECK   = 3'd2,
    UNLOCK  = 3'd3,
    FAIL    = 3'd4,
    LOCKOUT = 3'd5
  } state_t;

  localparam int DEF_NUM_KNOCKS   = 4;
  localparam int DEF_TICK_DIV     = 50_000;
  localparam int DEF_MIN_GAP_MS   = 50;
  localparam int DEF_SHORT_MAX_MS = 300;
  localparam int DEF_TIMEOUT_MS   = 1500;
  localparam int DEF_UNLOCK_MS    = 3000;
  localparam int DEF_MAX_FAILS    = 3;
  localparam int DEF_LOCKOUT_MS   = 30000;

  function automatic int ms_cnt_width(input int timeout_ms, input int unlock_ms,
                                      input int lockout_ms);
    int m;
    m = timeout_ms;
    if (unlock_ms > m)  m = unlock_ms;
    if (lockout_ms > m) m = lockout_ms;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/knock_pattern_lock_ctrl_ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV clocks, restartable via clr.
module ms_tick_gen
  import knock_lock_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (clr || tick) presc_d = '0;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) presc_q <= '0;
    else          presc_q <= presc_d;
  end

endmodule

// File: rtl/knock_pattern_lock_ctrl.sv
// Knock-rhythm lock sequencer: time-stamps knocks, classifies gaps, drives the magnet.
//   state   | meaning
//   IDLE    | locked, waiting for the first knock
//   COLLECT | timing gaps between knocks
//   CHECK   | one cycle, compare captured gaps to pattern
//   UNLOCK  | magnet released for UNLOCK_MS
//   FAIL    | one cycle, bump failure count
//   LOCKOUT | locked, knocks ignored for LOCKOUT_MS
module knock_pattern_lock_ctrl
  import knock_lock_pkg::*;
#(
  parameter int NUM_KNOCKS   = DEF_NUM_KNOCKS,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int MIN_GAP_MS   = DEF_MIN_GAP_MS,
  parameter int SHORT_MAX_MS = DEF_SHORT_MAX_MS,
  parameter int TIMEOUT_MS   = DEF_TIMEOUT_MS,
  parameter int UNLOCK_MS    = DEF_UNLOCK_MS,
  parameter int MAX_FAILS    = DEF_MAX_FAILS,
  parameter int LOCKOUT_MS   = DEF_LOCKOUT_MS
) (
  input  logic                               CLOCK_50,
  input  logic                               reset_n,
  input  logic                               knock_db,
  input  logic [NUM_KNOCKS-2:0]              pattern,
  output logic                               output_elmag,
  output logic                               unlocked_flag,
  output logic                               lockout_flag,
  output logic                               busy,
  output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count
);

  localparam int MS_W = ms_cnt_width(TIMEOUT_MS, UNLOCK_MS, LOCKOUT_MS);
  localparam int KC_W = $clog2(NUM_KNOCKS + 1);
  localparam int FC_W = $clog2(MAX_FAILS + 1);
  localparam int G_W  = NUM_KNOCKS - 1;

  state_t          state_q, state_d;
  logic            knock_q;
  logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [KC_W-1:0] knock_cnt_q, knock_cnt_d;
  logic [G_W-1:0]  gap_reg_q, gap_reg_d;
  logic [FC_W-1:0] fail_count_q, fail_count_d;

  logic knock, accept, timer_clr, tick;

  assign knock = knock_db & ~knock_q;

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .clr      (timer_clr),
    .tick     (tick)
  );

  always_comb begin
    state_d      = state_q;
    knock_cnt_d  = knock_cnt_q;
    gap_reg_d    = gap_reg_q;
    fail_count_d = fail_count_q;
    accept       = 1'b0;
    case (state_q)
      IDLE: begin
        if (knock) begin
          state_d     = COLLECT;
          knock_cnt_d = KC_W'(1);
          gap_reg_d   = '0;
        end
      end
      COLLECT: begin
        // Timeout has priority over a knock landing in the same cycle.
        if (ms_cnt_q >= MS_W'(TIMEOUT_MS)) begin
          state_d = FAIL;
        end else if (knock && (ms_cnt_q >= MS_W'(MIN_GAP_MS))) begin
          accept = 1'b1;
          for (int i = 0; i < G_W; i++) begin
            if (knock_cnt_q == KC_W'(i + 1)) gap_reg_d[i] = (ms_cnt_q >= MS_W'(SHORT_MAX_MS));
          end
          knock_cnt_d = knock_cnt_q + KC_W'(1);
          if (knock_cnt_d == KC_W'(NUM_KNOCKS)) state_d = CHECK;
        end
      end
      CHECK: begin
        if (gap_reg_q == pattern) begin
          state_d      = UNLOCK;
          fail_count_d = '0;
        end else begin
          state_d = FAIL;
        end
      end
      UNLOCK: begin
        if (ms_cnt_q == MS_W'(UNLOCK_MS)) state_d = IDLE;
      end
      FAIL: begin
        fail_count_d = fail_count_q + FC_W'(1);
        state_d      = (fail_count_d == FC_W'(MAX_FAILS)) ? LOCKOUT : IDLE;
      end
      LOCKOUT: begin
        if (ms_cnt_q == MS_W'(LOCKOUT_MS)) begin
          fail_count_d = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    timer_clr = accept | (state_d != state_q);
  end

  // Millisecond counter saturates so a long IDLE never wraps.
  always_comb begin
    ms_cnt_d = ms_cnt_q;
    if (timer_clr)                    ms_cnt_d = '0;
    else if (tick && (ms_cnt_q != '1)) ms_cnt_d = ms_cnt_q + MS_W'(1);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      knock_q      <= 1'b0;
      ms_cnt_q     <= '0;
      knock_cnt_q  <= '0;
      gap_reg_q    <= '0;
      fail_count_q <= '0;
    end else begin
      state_q      <= state_d;
      knock_q      <= knock_db;
      ms_cnt_q     <= ms_cnt_d;
      knock_cnt_q  <= knock_cnt_d;
      gap_reg_q    <= gap_reg_d;
      fail_count_q <= fail_count_d;
    end
  end

  assign output_elmag  = (state_q != UNLOCK);
  assign unlocked_flag = (state_q == UNLOCK);
  assign lockout_flag  = (state_q == LOCKOUT);
  assign busy          = (state_q != IDLE);
  assign fail_count    = fail_count_q;

endmodule

// File: tb/tb_knock_pattern_lock_ctrl.sv
// Directed bench for knock_pattern_lock_ctrl; 1 ms = 10 clocks.
module tb_knock_pattern_lock_ctrl;

  localparam int TD  = 10;
  localparam int UMS = 1050;
  localparam int LMS = 400;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       knock_db = 1'b0;
  logic [2:0] pattern  = 3'b101;
  logic       output_elmag, unlocked_flag, lockout_flag, busy;
  logic [1:0] fail_count;

  int vectors     = 0;
  int miscompares = 0;

  knock_pattern_lock_ctrl #(
    .NUM_KNOCKS (4),
    .TICK_DIV   (TD),
    .UNLOCK_MS  (UMS),
    .LOCKOUT_MS (LMS)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .reset_n       (reset_n),
    .knock_db      (knock_db),
    .pattern       (pattern),
    .output_elmag  (output_elmag),
    .unlocked_flag (unlocked_flag),
    .lockout_flag  (lockout_flag),
    .busy          (busy),
    .fail_count    (fail_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int elmag, input int unl, input int lck,
                            input int bsy, input int fc);
    check({tag, ".elmag"},    16'(output_elmag),  16'(elmag));
    check({tag, ".unlocked"}, 16'(unlocked_flag), 16'(unl));
    check({tag, ".lockout"},  16'(lockout_flag),  16'(lck));
    check({tag, ".busy"},     16'(busy),          16'(bsy));
    check({tag, ".fails"},    16'(fail_count),    16'(fc));
  endtask

  // Rising edge of knock_db lands c clocks after the previous detection edge.
  task automatic knock_after(input int c);
    repeat (c - 2) @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    knock_db = 1'b1;
    @(negedge CLOCK_50);
    knock_db = 1'b0;
  endtask

  task automatic knock();
    knock_after(2);
  endtask

  task automatic gap_knock(input int ms);
    knock_after(TD * ms + 5);
  endtask

  task automatic wrong_seq();
    knock();
    gap_knock(100);
    gap_knock(100);
    gap_knock(100);
  endtask

  initial begin
    repeat (3) @(negedge CLOCK_50);
    check_outs("reset", 1, 0, 0, 0, 0);
    reset_n = 1'b1;
    @(negedge CLOCK_50);

    // Correct rhythm 500/100/600 -> gaps 1,0,1; pattern only valid in the CHECK cycle.
    pattern = 3'b000;
    knock();
    check_outs("t1_collect", 1, 0, 0, 1, 0);
    gap_knock(500);
    gap_knock(100);
    gap_knock(600);
    pattern = 3'b101;
    check_outs("t1_check", 1, 0, 0, 1, 0);
    @(negedge CLOCK_50);
    pattern = 3'b000;
    check_outs("t1_unlock", 0, 1, 0, 1, 0);
    knock_after(100);
    check_outs("t1_knock_in_unlock", 0, 1, 0, 1, 0);
    repeat (TD * UMS - 100) @(negedge CLOCK_50);
    check_outs("t1_unlock_last", 0, 1, 0, 1, 0);
    @(negedge CLOCK_50);
    check_outs("t1_relock", 1, 0, 0, 0, 0);
    pattern = 3'b101;

    // Timeout with a knock arriving in the very cycle ms_cnt hits 1500.
    knock();
    repeat (TD * 1500) @(negedge CLOCK_50);
    check_outs("to_pending", 1, 0, 0, 1, 0);
    knock_db = 1'b1;
    @(negedge CLOCK_50);
    knock_db = 1'b0;
    check_outs("to_fail_state", 1, 0, 0, 1, 0);
    @(negedge CLOCK_50);
    check_outs("to_idle", 1, 0, 0, 0, 1);

    wrong_seq();
    @(negedge CLOCK_50);
    check_outs("wr_fail_state", 1, 0, 0, 1, 1);
    @(negedge CLOCK_50);
    check_outs("wr_idle", 1, 0, 0, 0, 2);

    // Correct rhythm with a bounce 20 ms after knock 2, starting from two failures.
    knock();
    gap_knock(500);
    knock_after(TD * 20 + 5);
    knock_after(TD * 80);
    gap_knock(600);
    check_outs("bnc_check", 1, 0, 0, 1, 2);
    @(negedge CLOCK_50);
    check_outs("bnc_unlock", 0, 1, 0, 1, 0);
    repeat (TD * 1000) @(negedge CLOCK_50);
    check_outs("bnc_mid_unlock", 0, 1, 0, 1, 0);
    reset_n = 1'b0;
    @(negedge CLOCK_50);
    check_outs("rst_in_unlock", 1, 0, 0, 0, 0);
    reset_n = 1'b1;
    @(negedge CLOCK_50);

    // Three wrong attempts -> lockout.
    for (int k = 1; k <= 2; k++) begin
      wrong_seq();
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      check_outs($sformatf("lo_idle%0d", k), 1, 0, 0, 0, k);
    end
    wrong_seq();
    @(negedge CLOCK_50);
    check_outs("lo_fail_state", 1, 0, 0, 1, 2);
    @(negedge CLOCK_50);
    check_outs("lo_enter", 1, 0, 1, 1, 3);
    knock_after(100);
    check_outs("lo_knock_ignored", 1, 0, 1, 1, 3);
    repeat (TD * LMS - 100) @(negedge CLOCK_50);
    check_outs("lo_last", 1, 0, 1, 1, 3);
    @(negedge CLOCK_50);
    check_outs("lo_exit", 1, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
